// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C burst write engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_DATA     = 3'd4,
    ST_DATA_ACK = 3'd5,
    ST_STOP     = 3'd6
  } i2c_tx_state_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NAK   = 1'b1;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Byte FIFO with synchronous push/pop/flush; push while full is allowed when a pop frees a slot.
module i2c_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/i2c_tx_burst.sv
// I2C controller burst write engine: START, address+W, FIFO-fed data bytes with ACK checks, STOP.
module i2c_tx_burst
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic             nak,
  output logic [LEN_W-1:0] sent_cnt,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_i,
  input  logic             sda_i
);

  localparam int unsigned   DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  i2c_tx_state_t    state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] sent_q, sent_d, sent_inc;
  logic             stall_q, stall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nak_q, nak_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;

  logic             div_hold, qtick, need_byte;
  logic             fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (wr_valid && wr_ready),
    .data_i  (wr_data),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_ready   = !fifo_full;
  assign fifo_flush = (state_q == ST_STOP) && nak_q;
  assign sent_inc   = sent_q + LEN_W'(1);

  // Divider freezes during underrun and while SCL is stretched low by the target.
  always_comb begin
    div_hold = stall_q;
    if (state_q == ST_STOP && qtr_q == 2'd1 && !scl_i) div_hold = 1'b1;
    if ((state_q inside {ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK}) &&
        qtr_q == 2'd2 && !scl_i) div_hold = 1'b1;
  end

  assign qtick = busy_q && !div_hold && (cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    len_d     = len_q;
    sent_d    = sent_q;
    stall_d   = stall_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nak_d     = nak_q;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;
    need_byte = stall_q;
    fifo_pop  = 1'b0;

    if (busy_q && !div_hold) begin
      cnt_d = qtick ? '0 : cnt_q + DIV_W'(1);
      if (qtick) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_START;
          busy_d   = 1'b1;
          sda_oe_d = 1'b1;
          nak_d    = 1'b0;
          sent_d   = '0;
          len_d    = len;
          shreg_d  = {addr, I2C_WRITE};
          cnt_d    = '0;
          qtr_d    = '0;
          stall_d  = 1'b0;
        end
      end
      ST_START: begin
        if (qtick && qtr_q == 2'd1) begin
          state_d  = ST_ADDR;
          qtr_d    = '0;
          bit_d    = 3'd7;
          scl_oe_d = 1'b1;
          sda_oe_d = ~shreg_q[7];
        end
      end
      ST_ADDR, ST_DATA: begin
        if (qtick && qtr_q == 2'd1) scl_oe_d = 1'b0;
        if (qtick && qtr_q == 2'd3) begin
          scl_oe_d = 1'b1;
          if (bit_q == 3'd0) begin
            state_d  = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
            sda_oe_d = 1'b0;
          end else begin
            bit_d    = bit_q - 3'd1;
            shreg_d  = {shreg_q[6:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
          end
        end
      end
      ST_ADDR_ACK: begin
        if (qtick && qtr_q == 2'd1) scl_oe_d = 1'b0;
        if (qtick && qtr_q == 2'd3) begin
          scl_oe_d = 1'b1;
          if (sda_i != I2C_ACK || len_q == '0) begin
            nak_d    = (sda_i == I2C_NAK);
            state_d  = ST_STOP;
            sda_oe_d = 1'b1;
          end else begin
            state_d   = ST_DATA;
            need_byte = 1'b1;
          end
        end
      end
      ST_DATA_ACK: begin
        if (qtick && qtr_q == 2'd1) scl_oe_d = 1'b0;
        if (qtick && qtr_q == 2'd3) begin
          scl_oe_d = 1'b1;
          if (sda_i == I2C_NAK) begin
            nak_d    = 1'b1;
            state_d  = ST_STOP;
            sda_oe_d = 1'b1;
          end else begin
            sent_d = sent_inc;
            if (sent_inc == len_q) begin
              state_d  = ST_STOP;
              sda_oe_d = 1'b1;
            end else begin
              state_d   = ST_DATA;
              need_byte = 1'b1;
            end
          end
        end
      end
      ST_STOP: begin
        if (qtick) begin
          case (qtr_q)
            2'd0: scl_oe_d = 1'b0;
            2'd1: sda_oe_d = 1'b0;
            2'd2: begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
              qtr_d   = '0;
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Fetch the next data byte; on underrun keep SCL low and restart Q0 once a byte lands.
    if (need_byte) begin
      bit_d = 3'd7;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        shreg_d  = fifo_head;
        sda_oe_d = ~fifo_head[7];
        stall_d  = 1'b0;
        cnt_d    = '0;
        qtr_d    = '0;
      end else begin
        stall_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      qtr_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      len_q    <= '0;
      sent_q   <= '0;
      stall_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nak_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      len_q    <= len_d;
      sent_q   <= sent_d;
      stall_q  <= stall_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nak_q    <= nak_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign nak      = nak_q;
  assign sent_cnt = sent_q;
  assign scl_oe   = scl_oe_q;
  assign sda_oe   = sda_oe_q;

endmodule

// File: doc/i2c_tx_burst.md
Name: i2c_tx_burst

Overview:
Parametrised I2C controller write engine, successor to the single-byte transmitter. Takes a 7-bit target address, a burst length and a byte stream through an internal FIFO. Generates START, address+W, data bytes, ACK checks and STOP on open-drain SCL/SDA. Adds a programmable SCL rate, FIFO buffering with underrun stall, clock-stretch support and NAK abort reporting.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter period (>= 2); bit period = 4*CLK_DIV
FIFO_DEPTH, 4, byte FIFO entries (power of two, >= 2)
LEN_W, 8, width of burst length and sent count

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only when busy=0
addr  in  7  target address, captured on accept
len  in  LEN_W  data bytes to send, captured on accept; 0 = address probe
wr_data  in  8  FIFO write byte
wr_valid  in  1  FIFO write strobe
wr_ready  out  1  FIFO not full; write happens on wr_valid & wr_ready
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at transaction end (success or NAK)
nak  out  1  sticky: last transaction ended on NAK; cleared on next accept
sent_cnt  out  LEN_W  bytes ACKed in current/last transaction
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release
scl_i  in  1  sampled SCL line (stretch detect)
sda_i  in  1  sampled SDA line (ACK sample)

Behaviour:
- Reset (async, immediate): scl_oe=0, sda_oe=0, busy=0, done=0, nak=0, sent_cnt=0, FIFO empty, wr_ready=1, state IDLE. Mid-transaction reset releases both lines in the same instant; no STOP is generated.
- Quarter-tick divider runs only when busy=1, and restarts at 0 on accept.
- States: IDLE -> START -> ADDR -> ADDR_ACK -> {DATA -> DATA_ACK}* -> STOP -> IDLE.
- Accept: start=1 & busy=0 at edge N -> busy=1, sda_oe=1, nak=0, sent_cnt=0 at N+1. SCL is still released at this point, which forms the START condition. After 2*CLK_DIV cycles scl_oe=1 and the FSM enters ADDR.
- Bit timing, quarters Q0..Q3, each CLK_DIV cycles:
  - Q0: scl_oe=1; sda_oe = ~bit, set at Q0 start.
  - Q1: hold.
  - Q2: scl_oe=0. The divider freezes until scl_i=1, which implements clock stretching of any length. Counting resumes the cycle after scl_i is seen high.
  - Q3: SCL high. In ACK states, sda_i is sampled on the last cycle of Q3.
- Bit order is MSB first. Address byte = {addr, 1'b0}. In ACK states sda_oe=0.
- ADDR_ACK: sda_i=0 -> DATA if len>0, else STOP; sda_i=1 -> nak=1, STOP.
- DATA byte source is the FIFO head, popped at Q0 of bit 7.
- Underrun: FIFO empty at that point -> hold scl_oe=1 (SCL low) and the divider until a byte arrives. The byte is then popped and Q0 restarts from the beginning.
- DATA_ACK: ACK -> sent_cnt+1; if sent_cnt==len -> STOP, else DATA. NAK -> nak=1, STOP, remaining FIFO contents flushed in STOP.
- STOP: Q0 scl_oe=1, sda_oe=1; after CLK_DIV scl_oe=0 (wait scl_i=1); after CLK_DIV sda_oe=0; after CLK_DIV busy=0 and done=1 for one cycle.
- FIFO writes are accepted any time, including preload while idle and during the transaction. Simultaneous push and pop when full is legal because the pop frees an entry in the same cycle.
- start while busy=1 is ignored. Excess bytes beyond len stay in the FIFO for the next transaction, except after NAK, where they are flushed.
- sent_cnt counts modulo 2^LEN_W. len is never exceeded.

Decomposition:
- Package i2c_pkg: state enum i2c_tx_state_t, constants I2C_WRITE=1'b0, I2C_ACK=1'b0, I2C_NAK=1'b1.
- Sub-module i2c_byte_fifo (DEPTH, synchronous push/pop/flush, full/empty).
- The FSM, divider and bit counter stay in i2c_tx_burst.

Test Plan:
- Single byte: preload 0xAA, start addr=0x50 len=1, VIP ACKs all. The VIP must see 0xA0 then 0xAA. Expect done pulse, nak=0, sent_cnt=1, bit period 16 clk with CLK_DIV=4.
- Address NAK: start addr=0x3C len=2 with 2 bytes preloaded, VIP NAKs the address. Expect STOP, nak=1, sent_cnt=0, FIFO empty (wr_ready=1, 4 writes accepted afterwards).
- Data NAK: bytes 0x77,0x33,0x22, VIP NAKs the 2nd byte. Expect nak=1, sent_cnt=1, and 0x22 is never driven on the bus.
- Underrun: len=2, only 0x55 preloaded, 0xF0 written 100 cycles after the first ACK. Expect SCL held low during the gap, then 0xF0 received and sent_cnt=2.
- Clock stretch: the VIP holds SCL low for 50 cycles at Q2 of address bit 3. The bit completes correctly, total duration is extended by about 50 cycles, and the received data is unchanged.
- Reset and probe: assert rstn=0 mid data byte, expecting scl_oe=sda_oe=0 and busy=0 immediately. Then start len=0 at addr 0x10. Expect only 0x20 plus ACK, then STOP, with done=1 and sent_cnt=0.
